// File: rtl/fdc_meas_ctrl_if.sv
// Result channel of the FDC measurement controller.
// Valid/ready handshake carrying the sum, average and overflow flag.
interface fdc_meas_ctrl_if;
    logic [7:0] res_data;
    logic [4:0] res_avg;
    logic       res_ovf;
    logic       res_valid;
    logic       res_ready;

    modport master (
        output res_data,
        output res_avg,
        output res_ovf,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_avg,
        input  res_ovf,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/fdc_meas_ctrl.sv
// FDC measurement sequencer: reset, settle, window, capture, N-sample sum.
// A start is registered once in IDLE, so the first RST entry is one edge later.
module fdc_meas_ctrl #(
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 2,
    parameter int WIN_CYC    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   sel,
    input  logic [1:0]             avg_log2,
    input  logic [4:0]             fdc_code,
    output logic                   fdc_reset,
    output logic                   fdc_selec,
    output logic                   busy,
    fdc_meas_ctrl_if.master        res
);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        MEAS,
        CAPT,
        DONE
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [9:0] cnt;
    logic       arm;
    logic       cfg_sel;
    logic [1:0] cfg_avg;
    logic [3:0] smp;
    logic [7:0] acc;
    logic       ovf;
    logic       hs;
    logic       last;
    logic       latch;

    assign hs    = (state == DONE) && res.res_ready;
    assign last  = (smp + 4'd1) >= (4'd1 << cfg_avg);
    assign latch = ((state == IDLE) && !arm && start)
                || (hs && cont);

    assign busy          = (state != IDLE);
    assign res.res_valid = (state == DONE);
    assign res.res_data  = acc;
    assign res.res_avg   = 5'(acc >> cfg_avg);
    assign res.res_ovf   = ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state decode; the shared counter ends each timed phase at zero.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (arm) nxt = RST;
            RST:     if (cnt == 10'd0) nxt = SETTLE;
            SETTLE:  if (cnt == 10'd0) nxt = MEAS;
            MEAS:    if (cnt == 10'd0) nxt = CAPT;
            CAPT:    nxt = last ? DONE : RST;
            DONE:    if (hs) nxt = cont ? RST : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Phase timer, FDC controls, config latch and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fdc_reset <= 1'b1;
            fdc_selec <= 1'b0;
            cnt       <= '0;
            arm       <= 1'b0;
            cfg_sel   <= 1'b0;
            cfg_avg   <= '0;
            smp       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            fdc_reset <= (nxt == RST);
            arm       <= (state == IDLE) && !arm && start;

            if (latch) begin
                cfg_sel <= sel;
                cfg_avg <= avg_log2;
                smp     <= '0;
                acc     <= '0;
                ovf     <= 1'b0;
            end

            if (nxt == RST && state != RST) begin
                cnt       <= 10'(RST_CYC - 1);
                fdc_selec <= (state == DONE) ? sel : cfg_sel;
            end else if (cnt != 10'd0) begin
                cnt <= cnt - 10'd1;
            end else if (state == RST) begin
                cnt <= 10'(SETTLE_CYC - 1);
            end else if (state == SETTLE) begin
                cnt <= 10'(WIN_CYC - 1);
            end

            if (state == CAPT) begin
                acc <= acc + {3'b000, fdc_code};
                smp <= smp + 4'd1;
                if (fdc_code == 5'd31) ovf <= 1'b1;
            end
        end
    end

endmodule
